// File: rtl/d_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package d_cache_pkg;

  // Controller states: idle, registered hit reply, memory request, memory wait.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIT   = 2'd1,
    S_MREQ  = 2'd2,
    S_MWAIT = 2'd3
  } state_t;

  // Access size encodings on both the core and memory side.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Word-align an address; a cached line fill always fetches the whole word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/d_cache_if.sv
// Sram-like bus used on both sides of the cache.
// Handshake: the master raises req with wr/size/addr/wdata and holds them
// stable until the cycle addr_ok is high (transfer accepted on that clock
// edge). The response arrives later as a one-cycle data_ok pulse, with rdata
// valid in that same cycle for reads. Only one transaction is ever in flight.
interface d_cache_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/d_cache_strobe.sv
// Byte-lane strobe from access size and the low address bits.
module d_cache_strobe
  import d_cache_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] offset,
  output logic [3:0] strobe
);

  // Decode which byte lanes of the word the access touches.
  always_comb begin
    strobe = 4'b0000;
    case (size)
      SIZE_BYTE: strobe = 4'b0001 << offset;
      SIZE_HALF: strobe = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: strobe = 4'b1111;
      default:   strobe = 4'b0000;
    endcase
  end

endmodule

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines. Sits between the core data port (cpu) and the memory-side port (mem).
// no_dcache forces the current request to bypass the arrays entirely.
module d_cache
  import d_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       no_dcache,
  d_cache_if.slave   cpu,
  d_cache_if.master  mem,
  output state_t     dbg_state
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 32 - INDEX_WIDTH - 2;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  state_t      state, state_nxt;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [1:0]  size_r;
  logic        wr_r, unc_r;

  logic [INDEX_WIDTH-1:0] in_idx, r_idx;
  logic [TAG_W-1:0]       in_tag, r_tag;
  logic                   in_hit, line_hit_r, accept, complete, fill, merge;
  logic [3:0]             strobe;
  logic [31:0]            merged;

  assign in_idx = cpu.addr[INDEX_WIDTH+1:2];
  assign in_tag = cpu.addr[31:INDEX_WIDTH+2];
  assign r_idx  = addr_r[INDEX_WIDTH+1:2];
  assign r_tag  = addr_r[31:INDEX_WIDTH+2];

  // Lookup at accept time; writes re-check the line at completion instead.
  assign in_hit     = valid[in_idx] & (tag_mem[in_idx] == in_tag) & ~no_dcache;
  assign line_hit_r = valid[r_idx] & (tag_mem[r_idx] == r_tag);
  assign accept     = cpu.req & (state == S_IDLE) & ~rst;
  assign complete   = (state == S_MWAIT) & mem.data_ok & ~rst;
  assign fill       = complete & ~wr_r & ~unc_r;
  assign merge      = complete & wr_r & ~unc_r & line_hit_r;
  assign dbg_state  = state;

  d_cache_strobe u_strobe (
    .size   (size_r),
    .offset (addr_r[1:0]),
    .strobe (strobe)
  );

  // Merge the write data into the resident word on the strobed lanes.
  always_comb begin
    merged = data_mem[r_idx];
    for (int b = 0; b < 4; b++) begin
      if (strobe[b]) merged[8*b +: 8] = wdata_r[8*b +: 8];
    end
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Latch the accepted request and the hit word so later cycles see stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= '0;
      wdata_r <= '0;
      size_r  <= '0;
      wr_r    <= 1'b0;
      unc_r   <= 1'b0;
      rdata_r <= '0;
    end else if (accept) begin
      addr_r  <= cpu.addr;
      wdata_r <= cpu.wdata;
      size_r  <= cpu.size;
      wr_r    <= cpu.wr;
      unc_r   <= no_dcache;
      rdata_r <= data_mem[in_idx];
    end
  end

  // Valid bits are the only array state that reset clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       valid <= '0;
    else if (fill) valid[r_idx] <= 1'b1;
  end

  // Tag/data arrays: fill on cached read miss, merge on cached write hit.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[r_idx]  <= r_tag;
      data_mem[r_idx] <= mem.rdata;
    end else if (merge) begin
      data_mem[r_idx] <= merged;
    end
  end

  // Next-state and bus outputs; every output idles at zero.
  always_comb begin
    state_nxt   = state;
    cpu.addr_ok = 1'b0;
    cpu.data_ok = 1'b0;
    cpu.rdata   = '0;
    mem.req     = 1'b0;
    mem.wr      = 1'b0;
    mem.size    = '0;
    mem.addr    = '0;
    mem.wdata   = '0;
    case (state)
      S_IDLE: begin
        cpu.addr_ok = cpu.req & ~rst;
        if (cpu.req) state_nxt = (in_hit & ~cpu.wr) ? S_HIT : S_MREQ;
      end
      S_HIT: begin
        cpu.data_ok = 1'b1;
        cpu.rdata   = rdata_r;
        state_nxt   = S_IDLE;
      end
      S_MREQ: begin
        mem.req   = 1'b1;
        mem.wr    = wr_r;
        mem.wdata = wdata_r;
        if (~wr_r & ~unc_r) begin
          mem.size = SIZE_WORD;
          mem.addr = word_align(addr_r);
        end else begin
          mem.size = size_r;
          mem.addr = addr_r;
        end
        if (mem.addr_ok) state_nxt = S_MWAIT;
      end
      S_MWAIT: begin
        if (mem.data_ok) begin
          cpu.data_ok = 1'b1;
          cpu.rdata   = wr_r ? 32'h0 : mem.rdata;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_d_cache.sv
// Bench for d_cache: directed core accesses, a small memory responder and
// scoreboards for both the core response and the memory-side request.
module tb_d_cache;
  import d_cache_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   no_dcache = 1'b0;
  state_t dbg_state;

  d_cache_if cpu ();
  d_cache_if mem ();

  d_cache #(.INDEX_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .no_dcache (no_dcache),
    .cpu       (cpu),
    .mem       (mem),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cycle = 0;
  int done_cnt = 0;
  int last_ok_cycle = 0;
  int mem_lat = 1;

  always @(posedge clk) cycle <= cycle + 1;

  logic [32:0] exp_q[$];    // {wr, expected rdata}
  logic [66:0] mreq_q[$];   // {wr, size, addr, wdata}
  logic [31:0] mem_words [logic [31:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: timeout or unexpected event", name);
  endtask

  // ---------------- memory responder ----------------
  int          rsp_phase = 0;
  int          rsp_cnt = 0;
  logic [66:0] rsp_cur;

  task automatic mem_do(input logic [66:0] r, output logic [31:0] rd);
    logic [31:0] key, w;
    logic [1:0]  sz, off;
    key = {r[63:34], 2'b00};
    sz  = r[65:64];
    off = r[33:32];
    w   = mem_words.exists(key) ? mem_words[key] : 32'h0;
    rd  = w;
    if (r[66]) begin
      for (int b = 0; b < 4; b++) begin
        if (sz == 2'd2 || (sz == 2'd1 && b[1] == off[1]) || (sz == 2'd0 && b[1:0] == off))
          w[8*b +: 8] = r[8*b +: 8];
      end
      mem_words[key] = w;
    end
  endtask

  initial begin
    mem.addr_ok = 1'b0;
    mem.data_ok = 1'b0;
    mem.rdata   = '0;
    forever begin
      @(posedge clk); #1;
      mem.addr_ok = 1'b0;
      mem.data_ok = 1'b0;
      mem.rdata   = '0;
      if (rst) rsp_phase = 0;
      else if (rsp_phase == 0) begin
        if (mem.req) begin
          rsp_cur = {mem.wr, mem.size, mem.addr, mem.wdata};
          mem.addr_ok = 1'b1;
          rsp_phase = 1;
          rsp_cnt = 0;
        end
      end else begin
        if (rsp_cnt >= mem_lat) begin
          mem.data_ok = 1'b1;
          mem_do(rsp_cur, mem.rdata);
          rsp_phase = 0;
        end else rsp_cnt++;
      end
    end
  end

  // ---------------- monitors ----------------
  // Core response: pop expected reply on every data_ok.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && cpu.data_ok) begin
        done_cnt++;
        last_ok_cycle = cycle;
        check("ok_without_mem_req", mem.req, 1'b0);
        if (exp_q.size() == 0) fail_now("unexpected_data_ok");
        else begin
          e = exp_q.pop_front();
          if (!e[32]) check("rdata", cpu.rdata, e[31:0]);
        end
      end
    end
  end

  // Memory request: pop expected request on every accepted handshake.
  initial begin
    logic [66:0] m;
    forever begin
      @(negedge clk);
      if (!rst && mem.req && mem.addr_ok) begin
        if (mreq_q.size() == 0) fail_now("unexpected_mem_req");
        else begin
          m = mreq_q.pop_front();
          check("mem_wr", mem.wr, m[66]);
          check("mem_size", mem.size, m[65:64]);
          check("mem_addr", mem.addr, m[63:32]);
          if (m[66]) check("mem_wdata", mem.wdata, m[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cpu_access(input string name, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic unc,
                            input logic [31:0] exp_rdata, input logic exp_mem,
                            input logic [1:0] msize, input logic [31:0] maddr, input bit chk_lat);
    int  start_done, acc_cycle;
    bit  ok;
    exp_q.push_back({wr, exp_rdata});
    if (exp_mem) mreq_q.push_back({wr, msize, maddr, wdata});
    start_done = done_cnt;
    @(posedge clk); #1;
    cpu.req = 1'b1; cpu.wr = wr; cpu.size = size; cpu.addr = addr; cpu.wdata = wdata;
    no_dcache = unc;
    ok = 1'b0;
    acc_cycle = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu.addr_ok) begin ok = 1'b1; acc_cycle = cycle; break; end
    end
    @(posedge clk); #1;
    cpu.req = 1'b0; no_dcache = 1'b0;
    if (!ok) begin fail_now({name, "_accept"}); return; end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != start_done) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    if (!ok) fail_now({name, "_done"});
    else if (chk_lat) check({name, "_hit_latency"}, last_ok_cycle - acc_cycle, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    cpu.req = 1'b0; cpu.wr = 1'b0; cpu.size = '0; cpu.addr = '0; cpu.wdata = '0;
    mem_words[32'h1fc0_0100] = 32'h1234_5678;
    mem_words[32'h1faf_f000] = 32'hcafe_f00d;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dbg_state, S_IDLE);
    check("reset_cpu_out", {cpu.addr_ok, cpu.data_ok, cpu.rdata}, '0);
    check("reset_mem_out", {mem.req, mem.wr, mem.size, mem.addr, mem.wdata}, '0);
    rst = 1'b0;

    // 1: cold read miss, word fetch
    cpu_access("cold_read", 0, 2'd2, 32'h1fc0_0100, 0, 0, 32'h1234_5678, 1, 2'd2, 32'h1fc0_0100, 0);
    // 2: repeat read hits in one cycle
    cpu_access("hit_read", 0, 2'd2, 32'h1fc0_0100, 0, 0, 32'h1234_5678, 0, 2'd0, 0, 1);
    // 3: byte write hit, forwarded unchanged, merged
    cpu_access("sb_hit", 1, 2'd0, 32'h1fc0_0101, 32'h0000_ab00, 0, 0, 1, 2'd0, 32'h1fc0_0101, 0);
    cpu_access("read_after_sb", 0, 2'd2, 32'h1fc0_0100, 0, 0, 32'h1234_ab78, 0, 2'd0, 0, 1);
    cpu_access("sh_hit", 1, 2'd1, 32'h1fc0_0102, 32'hbeef_0000, 0, 0, 1, 2'd1, 32'h1fc0_0102, 0);
    cpu_access("read_after_sh", 0, 2'd2, 32'h1fc0_0100, 0, 0, 32'hbeef_ab78, 0, 2'd0, 0, 1);
    // 4: write miss does not allocate
    cpu_access("sw_miss", 1, 2'd2, 32'h0000_2000, 32'hdead_beef, 0, 0, 1, 2'd2, 32'h0000_2000, 0);
    cpu_access("read_after_sw_miss", 0, 2'd2, 32'h0000_2000, 0, 0, 32'hdead_beef, 1, 2'd2, 32'h0000_2000, 0);
    cpu_access("read_2000_hit", 0, 2'd2, 32'h0000_2000, 0, 0, 32'hdead_beef, 0, 2'd0, 0, 1);
    // 5: uncached reads pass size/addr and never fill
    mem_lat = 3;
    cpu_access("unc_read_a", 0, 2'd1, 32'h1faf_f002, 0, 1, 32'hcafe_f00d, 1, 2'd1, 32'h1faf_f002, 0);
    cpu_access("unc_read_b", 0, 2'd1, 32'h1faf_f002, 0, 1, 32'hcafe_f00d, 1, 2'd1, 32'h1faf_f002, 0);
    mem_lat = 0;
    cpu_access("cached_half_miss", 0, 2'd1, 32'h1faf_f002, 0, 0, 32'hcafe_f00d, 1, 2'd2, 32'h1faf_f000, 0);
    // same index, different tag: line was replaced
    cpu_access("replaced_line", 0, 2'd2, 32'h0000_2000, 0, 0, 32'hdead_beef, 1, 2'd2, 32'h0000_2000, 0);

    // 6: reset while waiting on memory
    mem_lat = 20;
    mreq_q.push_back({1'b0, 2'd2, 32'h0000_3000, 32'h0});
    @(posedge clk); #1;
    cpu.req = 1'b1; cpu.wr = 1'b0; cpu.size = 2'd2; cpu.addr = 32'h0000_3000; cpu.wdata = '0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu.addr_ok) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cpu.req = 1'b0;
    if (!ok) fail_now("rst_test_accept");
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_state", dbg_state, S_MWAIT);
    rst = 1'b1;
    #1;
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_cpu_out", {cpu.addr_ok, cpu.data_ok, cpu.rdata}, '0);
    check("mid_rst_mem_out", {mem.req, mem.wr, mem.size, mem.addr, mem.wdata}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_lat = 1;
    cpu_access("reread_after_rst", 0, 2'd2, 32'h1fc0_0100, 0, 0, 32'hbeef_ab78, 1, 2'd2, 32'h1fc0_0100, 0);

    repeat (5) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("mreq_q_drained", mreq_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
